// File: rtl/fft_pkg.sv
// Shared constants, controller state encoding and bit-reverse helper for the FFT family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_pkg;

  localparam int N     = 16;
  localparam int LOG2N = 4;
  localparam int DW    = 16;

  // IDLE -> LOAD -> (ISSUE -> WAIT -> WRITE) x32 -> UNLOAD -> IDLE
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    WRITE  = 3'd4,
    UNLOAD = 3'd5
  } state_t;

  // Reverses the 4-bit sample index so the DIT butterflies find their inputs
  // in the order the in-place schedule expects.
  function automatic logic [3:0] bitrev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT in-place address/twiddle generator: (stage, butterfly) -> (addr_a, addr_b, twiddle).
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the inputs.
//
// Ports:
//   stage   : stage s, 0..3
//   bfly    : butterfly b within the stage, 0..7
//   addr_a  : grp*2*span + pos
//   addr_b  : addr_a + span
//   twiddle : k of W16^k, pos << (3-s)
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [1:0]       stage,
  input  logic [2:0]       bfly,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-1:0] twiddle
);

  logic [3:0] span;
  logic [3:0] pos;
  logic [3:0] grp;

  always_comb begin
    span    = 4'd1 << stage;
    pos     = {1'b0, bfly} & (span - 4'd1);
    grp     = {1'b0, bfly} >> stage;
    // Two shifts rather than << (stage+1): the 2-bit sum would wrap at s=3.
    // grp*2*span never exceeds 14, so 4 bits hold the result.
    addr_a  = ((grp << stage) << 1) + pos;
    addr_b  = addr_a + span;
    // pos < span, so pos << (3-s) stays below 8.
    twiddle = pos << (2'd3 - stage);
  end

endmodule

// File: rtl/fft16_bfu_sequencer.sv
// 16-point radix-2 DIT FFT controller that time-shares one external butterfly unit.
// Latency: 16 load cycles + 32*(L+2) compute cycles + 16 unload cycles (L = butterfly latency).
// Backpressure: in_valid/in_ready during LOAD; out_valid held with stable data until out_ready.
//
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   start                  : begin a transform (sampled only in IDLE)
//   in_valid/in_ready      : sample handshake, in_real/in_imag in natural order
//   out_valid/out_ready    : bin handshake, out_real/out_imag/out_index in natural bin order
//   busy, done             : busy outside IDLE; done pulses once after bin 15 is accepted
//   bf_ra/ca/rb/cb         : butterfly operands A and B, bf_twiddle selects W16^k
//   bf_new_input_flag      : one-cycle issue strobe
//   bf_oa_*/bf_ob_*        : butterfly results, valid when bf_ready_flag is high
module fft16_bfu_sequencer #(
  parameter int N  = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic [3:0]    out_index,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] bf_ra,
  output logic [DW-1:0] bf_ca,
  output logic [DW-1:0] bf_rb,
  output logic [DW-1:0] bf_cb,
  output logic [3:0]    bf_twiddle,
  output logic          bf_new_input_flag,
  input  logic [DW-1:0] bf_oa_r,
  input  logic [DW-1:0] bf_oa_c,
  input  logic [DW-1:0] bf_ob_r,
  input  logic [DW-1:0] bf_ob_c,
  input  logic          bf_ready_flag
);

  import fft_pkg::*;

  localparam int         NBF         = (N / 2) * LOG2N;
  localparam logic [4:0] LAST_SAMPLE = 5'(N - 1);
  localparam logic [4:0] LAST_BF     = 5'(NBF - 1);

  state_t state_q, state_d;

  // One counter serves all phases: sample n in LOAD, butterfly {s,b} during
  // compute, bin address in UNLOAD. It is cleared on every phase change.
  logic [4:0] cnt_q, cnt_d;

  logic [2*DW-1:0] mem [0:N-1];

  logic [3:0]      gen_a, gen_b, gen_tw;
  logic [3:0]      wa_q, wb_q;
  logic [2*DW-1:0] res_a_q, res_b_q;
  logic            load_acc;

  // Addresses are generated for the butterfly about to be issued (cnt_d), so
  // operands can be read on the very edge that enters ISSUE.
  fft_addr_gen u_addr_gen (
    .stage   (cnt_d[4:3]),
    .bfly    (cnt_d[2:0]),
    .addr_a  (gen_a),
    .addr_b  (gen_b),
    .twiddle (gen_tw)
  );

  assign load_acc = (state_q == LOAD) && in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = 5'd0;
        end
      end
      LOAD: begin
        if (in_valid && in_ready) begin
          if (cnt_q == LAST_SAMPLE) begin
            state_d = ISSUE;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bf_ready_flag) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (cnt_q == LAST_BF) begin
          state_d = UNLOAD;
          cnt_d   = 5'd0;
        end else begin
          state_d = ISSUE;
          cnt_d   = cnt_q + 5'd1;
        end
      end
      UNLOAD: begin
        if (out_valid && out_ready) begin
          if (cnt_q == LAST_SAMPLE) begin
            state_d = IDLE;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      cnt_q             <= 5'd0;
      in_ready          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      bf_new_input_flag <= 1'b0;
      out_valid         <= 1'b0;
      out_real          <= '0;
      out_imag          <= '0;
      out_index         <= 4'd0;
      bf_ra             <= '0;
      bf_ca             <= '0;
      bf_rb             <= '0;
      bf_cb             <= '0;
      bf_twiddle        <= 4'd0;
      wa_q              <= 4'd0;
      wb_q              <= 4'd0;
      res_a_q           <= '0;
      res_b_q           <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      // Status outputs are registered from the next state so they line up
      // exactly with the state they describe.
      in_ready          <= (state_d == LOAD);
      busy              <= (state_d != IDLE);
      done              <= (state_q == UNLOAD) && (state_d == IDLE);
      bf_new_input_flag <= (state_d == ISSUE);

      // Operand read shares an edge with the previous WRITE. No bypass is
      // needed: butterflies of one stage touch disjoint addresses, and at
      // each stage boundary the last write pair ({14,15},{13,15},{11,15})
      // never overlaps the first read pair ({0,2},{0,4},{0,8}).
      if (state_d == ISSUE) begin
        {bf_ra, bf_ca} <= mem[gen_a];
        {bf_rb, bf_cb} <= mem[gen_b];
        bf_twiddle     <= gen_tw;
        wa_q           <= gen_a;
        wb_q           <= gen_b;
      end

      if ((state_q == WAIT) && bf_ready_flag) begin
        res_a_q <= {bf_oa_r, bf_oa_c};
        res_b_q <= {bf_ob_r, bf_ob_c};
      end

      // Without a handshake cnt_d == cnt_q, so the same bin is re-read and
      // the presented data stays stable under backpressure.
      out_valid <= (state_d == UNLOAD);
      if (state_d == UNLOAD) begin
        {out_real, out_imag} <= mem[cnt_d[3:0]];
        out_index            <= cnt_d[3:0];
      end
    end
  end

  // Sample store: not reset, contents only matter after a complete LOAD.
  // LOAD writes one port, WRITE uses both ports in the same cycle.
  always_ff @(posedge clk) begin
    if (load_acc) begin
      mem[bitrev4(cnt_q[3:0])] <= {in_real, in_imag};
    end
    if (state_q == WRITE) begin
      mem[wa_q] <= res_a_q;
      mem[wb_q] <= res_b_q;
    end
  end

endmodule

// File: tb/tb_fft16_bfu_sequencer.sv
module tb_fft16_bfu_sequencer;

  localparam int  DW = 16;
  localparam real PI = 3.14159265358979323846;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          start     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_real   = '0;
  logic [DW-1:0] in_imag   = '0;
  logic          in_ready, out_valid, busy, done, bf_new_input_flag, bf_ready_flag;
  logic [DW-1:0] out_real, out_imag, bf_ra, bf_ca, bf_rb, bf_cb;
  logic [DW-1:0] bf_oa_r, bf_oa_c, bf_ob_r, bf_ob_c;
  logic [3:0]    out_index, bf_twiddle;

  always #5 clk = ~clk;

  fft16_bfu_sequencer #(.N(16), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_index(out_index), .busy(busy), .done(done),
    .bf_ra(bf_ra), .bf_ca(bf_ca), .bf_rb(bf_rb), .bf_cb(bf_cb), .bf_twiddle(bf_twiddle),
    .bf_new_input_flag(bf_new_input_flag),
    .bf_oa_r(bf_oa_r), .bf_oa_c(bf_oa_c), .bf_ob_r(bf_ob_r), .bf_ob_c(bf_ob_c),
    .bf_ready_flag(bf_ready_flag)
  );

  // ---------------- butterfly stub ----------------
  int   lat       = 3;
  int   mode      = 0;   // 0: pass-through, 1: ideal unscaled butterfly
  int   issue_cnt = 0;
  int   stab_err  = 0;
  int   done_cnt  = 0;
  int   rem       = 0;
  logic stub_rdy  = 1'b0;
  logic pend      = 1'b0;
  logic force_il  = 1'b0;
  logic force_iss = 1'b0;
  logic [DW-1:0] log_ra[$];
  logic [DW-1:0] log_rb[$];
  logic [3:0]    log_tw[$];
  logic [DW-1:0] cap_ra, cap_ca, cap_rb, cap_cb;
  logic [3:0]    cap_tw;
  logic [DW-1:0] t_ar, t_ai, t_br, t_bi;

  assign bf_ready_flag = stub_rdy | (force_il & (!busy | in_ready)) | (force_iss & bf_new_input_flag);

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic void ideal_bf(input logic [DW-1:0] ar, ai, br, bi, input logic [3:0] k,
                                   output logic [DW-1:0] oar, oai, obr, obi);
    real ang, wr, wi, tr, ti;
    int  itr, iti;
    ang = 2.0 * PI * real'(k) / 16.0;
    wr  = $cos(ang);
    wi  = -$sin(ang);
    tr  = real'($signed(br)) * wr - real'($signed(bi)) * wi;
    ti  = real'($signed(br)) * wi + real'($signed(bi)) * wr;
    itr = rnd(tr);
    iti = rnd(ti);
    oar = 16'(int'($signed(ar)) + itr);
    oai = 16'(int'($signed(ai)) + iti);
    obr = 16'(int'($signed(ar)) - itr);
    obi = 16'(int'($signed(ai)) - iti);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_rdy <= 1'b0;
      pend     <= 1'b0;
      rem      <= 0;
    end else begin
      stub_rdy <= 1'b0;
      if (bf_new_input_flag) begin
        issue_cnt <= issue_cnt + 1;
        log_ra.push_back(bf_ra);
        log_rb.push_back(bf_rb);
        log_tw.push_back(bf_twiddle);
        {cap_ra, cap_ca, cap_rb, cap_cb, cap_tw} <= {bf_ra, bf_ca, bf_rb, bf_cb, bf_twiddle};
        if (mode == 0) begin
          t_ar = bf_ra; t_ai = bf_ca; t_br = bf_rb; t_bi = bf_cb;
        end else begin
          ideal_bf(bf_ra, bf_ca, bf_rb, bf_cb, bf_twiddle, t_ar, t_ai, t_br, t_bi);
        end
        bf_oa_r <= t_ar; bf_oa_c <= t_ai; bf_ob_r <= t_br; bf_ob_c <= t_bi;
        if (lat <= 1) begin
          stub_rdy <= 1'b1;
        end else begin
          pend <= 1'b1;
          rem  <= lat - 1;
        end
      end else if (pend) begin
        if ({bf_ra, bf_ca, bf_rb, bf_cb, bf_twiddle} !== {cap_ra, cap_ca, cap_rb, cap_cb, cap_tw})
          stab_err <= stab_err + 1;
        if (rem == 1) begin
          stub_rdy <= 1'b1;
          pend     <= 1'b0;
        end
        rem <= rem - 1;
      end
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // ---------------- checking helpers ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input logic [DW-1:0] act, input real exp, input int tol);
    real d;
    n_chk++;
    d = real'($signed(act)) - exp;
    if (d < 0.0) d = -d;
    if ((^act === 1'bx) || d > real'(tol)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0.2f (tol %0d)", nm, $signed(act), exp, tol);
    end
  endtask

  function automatic logic [3:0] brev(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_ctrl"}, {in_ready, out_valid, busy, done, bf_new_input_flag}, 5'b0);
    chk({tag, "_out"}, {out_real, out_imag, out_index}, 36'h0);
    chk({tag, "_opa"}, {bf_ra, bf_ca}, 32'h0);
    chk({tag, "_opb"}, {bf_rb, bf_cb}, 32'h0);
    chk({tag, "_tw"}, bf_twiddle, 4'h0);
  endtask

  // ---------------- transform driver ----------------
  logic [DW-1:0] xr[16], xi[16], got_r[16], got_i[16];
  logic [3:0]    got_idx[16];
  int            comp_cyc, issue0;

  task automatic kick();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_to_load", {in_ready, busy}, 2'b11);
  endtask

  task automatic load_samples(input bit rv, input bit spam);
    int i = 0;
    int cyc = 0;
    while (i < 16 && cyc < 2000) begin
      in_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
      in_real  = xr[i];
      in_imag  = xi[i];
      start    = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      if (in_valid && in_ready) i++;
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("load_count", i, 16);
  endtask

  task automatic run_tf(input int l, input int md, input bit rv, input int hold_bin, input bit spam);
    int i, cyc, hold, dc0;
    logic [DW-1:0] hr, hi;
    lat = l; mode = md; dc0 = done_cnt; issue0 = issue_cnt;
    kick();
    load_samples(rv, spam);
    chk("issue_after_load", bf_new_input_flag, 1'b1);
    comp_cyc = 0; cyc = 0;
    while (!out_valid && cyc < 5000) begin
      if (busy && !in_ready) comp_cyc++;
      if (spam) begin
        start = 1'($urandom_range(0, 1)); in_valid = 1'b1; in_real = 16'hdead; in_imag = 16'hbeef;
      end
      @(negedge clk); cyc++;
    end
    start = 1'b0; in_valid = 1'b0;
    chk("unload_starts", {out_valid, out_index}, 5'b1_0000);
    chk("issue_total", issue_cnt - issue0, 32);
    i = 0; cyc = 0; hold = 0; hr = '0; hi = '0;
    while (i < 16 && cyc < 2000) begin
      if (i == hold_bin && hold < 5) begin
        out_ready = 1'b0;
        if (hold == 0) begin
          hr = out_real; hi = out_imag;
        end else begin
          chk("hold_stable", {out_valid, out_index, out_real, out_imag}, {1'b1, 4'(i), hr, hi});
        end
        hold++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        got_r[i] = out_real; got_i[i] = out_imag; got_idx[i] = out_index; i++;
      end
      @(negedge clk); cyc++;
    end
    out_ready = 1'b0;
    chk("unload_cycles", cyc, (hold_bin >= 0) ? 21 : 16);
    chk("done_and_idle", {done, busy}, 2'b10);
    @(negedge clk);
    chk("done_once", done_cnt - dc0, 1);
  endtask

  task automatic check_perm(input string tag);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_bin%0d", tag, k), {got_idx[k], got_r[k], got_i[k]},
          {4'(k), xr[brev(4'(k))], xi[brev(4'(k))]});
    end
  endtask

  task automatic check_impulse(input string tag);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_bin%0d", tag, k), {got_idx[k], got_r[k], got_i[k]}, {4'(k), 16'h0100, 16'h0000});
    end
  endtask

  // ---------------- test ----------------
  typedef struct { int s; int b; int a; int bb; int tw; } addr_vec_t;
  addr_vec_t avec[8];
  int        exp_bins[16];

  initial begin
    int lb, idx;
    logic [DW-1:0] v;
    real er, ei, ang;

    avec[0] = '{0, 0, 0, 1, 0};
    avec[1] = '{1, 1, 1, 3, 4};
    avec[2] = '{2, 3, 3, 7, 6};
    avec[3] = '{3, 7, 7, 15, 7};
    avec[4] = '{0, 7, 14, 15, 0};
    avec[5] = '{1, 0, 0, 2, 0};
    avec[6] = '{2, 7, 11, 15, 6};
    avec[7] = '{3, 5, 5, 13, 5};
    exp_bins = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Address sequence and bit-reversed load (pass-through, L=3)
    for (int n = 0; n < 16; n++) begin xr[n] = 16'(n); xi[n] = 16'(16'h0100 + n); end
    lb = log_ra.size();
    run_tf(3, 0, 0, -1, 0);
    chk("compute_L3", comp_cyc, 32 * 5);
    chk("operand_stable", stab_err, 0);
    for (int t = 0; t < 8; t++) begin
      idx = lb + avec[t].s * 8 + avec[t].b;
      v = log_ra[idx];
      chk($sformatf("addrA_s%0d_b%0d", avec[t].s, avec[t].b), brev(v[3:0]), avec[t].a);
      v = log_rb[idx];
      chk($sformatf("addrB_s%0d_b%0d", avec[t].s, avec[t].b), brev(v[3:0]), avec[t].bb);
      chk($sformatf("twid_s%0d_b%0d", avec[t].s, avec[t].b), log_tw[idx], avec[t].tw);
    end
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("bitrev_bin%0d", k), {got_r[k], got_i[k]},
          {16'(exp_bins[k]), 16'(16'h0100 + exp_bins[k])});
    end

    // Impulse through the ideal butterfly
    for (int n = 0; n < 16; n++) begin xr[n] = '0; xi[n] = '0; end
    xr[0] = 16'h0100;
    run_tf(3, 1, 0, -1, 0);
    check_impulse("impulse");

    // Backpressure: random in_valid, bin 6 held 5 cycles, L=1 then L=7
    for (int n = 0; n < 16; n++) begin xr[n] = 16'($urandom); xi[n] = 16'($urandom); end
    run_tf(1, 0, 1, 6, 0);
    chk("compute_L1", comp_cyc, 32 * 3);
    check_perm("bp_L1");
    for (int n = 0; n < 16; n++) begin xr[n] = 16'($urandom); xi[n] = 16'($urandom); end
    run_tf(7, 0, 1, -1, 0);
    chk("compute_L7", comp_cyc, 32 * 9);
    check_perm("bp_L7");

    // Spurious bf_ready_flag in IDLE/LOAD/ISSUE, start and in_valid while busy
    force_il = 1'b1; force_iss = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ignores_ready", {busy, in_ready}, 2'b00);
    for (int n = 0; n < 16; n++) begin xr[n] = 16'($urandom); xi[n] = 16'($urandom); end
    run_tf(3, 0, 1, -1, 1);
    force_il = 1'b0; force_iss = 1'b0;
    chk("compute_spurious", comp_cyc, 32 * 5);
    check_perm("spurious");
    chk("operand_stable2", stab_err, 0);

    // Reset during stage 2 WAIT, then a fresh impulse
    for (int n = 0; n < 16; n++) begin xr[n] = '0; xi[n] = '0; end
    xr[0] = 16'h0100;
    lat = 3; mode = 1; lb = issue_cnt;
    kick();
    load_samples(0, 0);
    idx = 0;
    while (!((issue_cnt - lb) >= 17 && !bf_new_input_flag && busy) && idx < 2000) begin
      @(negedge clk); idx++;
    end
    chk("reached_stage2_wait", idx < 2000, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midreset");
    rst = 1'b0;
    @(negedge clk);
    run_tf(3, 1, 0, -1, 0);
    check_impulse("post_reset");

    // Randomised transforms vs a direct DFT
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 16; n++) begin
        xr[n] = 16'($urandom_range(0, 511) - 256);
        xi[n] = 16'($urandom_range(0, 511) - 256);
      end
      run_tf($urandom_range(1, 4), 1, 1, -1, 0);
      for (int k = 0; k < 16; k++) begin
        er = 0.0; ei = 0.0;
        for (int n = 0; n < 16; n++) begin
          ang = 2.0 * PI * real'((n * k) % 16) / 16.0;
          er += real'($signed(xr[n])) * $cos(ang) + real'($signed(xi[n])) * $sin(ang);
          ei += real'($signed(xi[n])) * $cos(ang) - real'($signed(xr[n])) * $sin(ang);
        end
        chk_tol($sformatf("dft%0d_bin%0d_re", r, k), got_r[k], er, 4);
        chk_tol($sformatf("dft%0d_bin%0d_im", r, k), got_i[k], ei, 4);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
